// File: rtl/gf_serial_mul_if.sv
// Operand/result handshake bundle for the serial GF(2^W) multiplier.
interface gf_serial_mul_if #(
    parameter int unsigned W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] prod;

    // Producer/consumer side (drives operands, accepts the product)
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, prod
    );

    // Multiplier side
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, prod
    );
endinterface

// File: rtl/gf_serial_mul.sv
// Sequential GF(2^W) multiplier: MSB-first Horner iteration, DIGIT bits of b per cycle.
module gf_serial_mul #(
    parameter int unsigned    W     = 8,
    parameter logic [W-1:0]   POLY  = W'(8'h1B),
    parameter int unsigned    DIGIT = 1
) (
    input  logic            clk,
    input  logic            rst,
    gf_serial_mul_if.slave  bus
);
    localparam int unsigned N  = W / DIGIT;
    localparam int unsigned CW = $clog2(N) + 1;

    // Reject illegal field widths and digit sizes at elaboration
    if ((DIGIT == 0) || (W < 2) || (W > 16) || ((W % DIGIT) != 0)) begin : g_bad_param
        $error("gf_serial_mul: W must be 2..16 and divisible by DIGIT");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_d;
    logic           in_rdy;
    logic           in_rdy_d;
    logic           out_vld;
    logic           out_vld_d;
    logic [W-1:0]   areg;
    logic [W-1:0]   breg;
    logic [W-1:0]   acc;
    logic [W-1:0]   prod_r;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   acc_step;
    logic [W-1:0]   b_step;

    // Multiply by x modulo the field polynomial
    function automatic logic [W-1:0] xtime(input logic [W-1:0] v);
        return {v[W-2:0], 1'b0} ^ (v[W-1] ? POLY : '0);
    endfunction

    // DIGIT unrolled Horner steps consuming breg from its MSB
    always_comb begin
        acc_step = acc;
        b_step   = breg;
        for (int i = 0; i < int'(DIGIT); i++) begin
            acc_step = xtime(acc_step) ^ (b_step[W-1] ? areg : '0);
            b_step   = {b_step[W-2:0], 1'b0};
        end
    end

    // Next-state and registered handshake flag decode
    always_comb begin
        state_d   = state;
        in_rdy_d  = 1'b0;
        out_vld_d = 1'b0;
        unique case (state)
            S_IDLE: if (bus.in_valid && in_rdy) state_d = S_CALC;
            S_CALC: if (cnt == '0) state_d = S_DONE;
            S_DONE: if (out_vld && bus.out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        in_rdy_d  = (state_d == S_IDLE);
        out_vld_d = (state_d == S_DONE);
    end

    // State register with handshake flags held low during reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            in_rdy  <= 1'b0;
            out_vld <= 1'b0;
        end else begin
            state   <= state_d;
            in_rdy  <= in_rdy_d;
            out_vld <= out_vld_d;
        end
    end

    // Operand load, iteration and result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            areg   <= '0;
            breg   <= '0;
            acc    <= '0;
            cnt    <= '0;
            prod_r <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.in_valid && in_rdy) begin
                        areg <= bus.a;
                        breg <= bus.b;
                        acc  <= '0;
                        cnt  <= CW'(N - 1);
                    end
                end
                S_CALC: begin
                    acc  <= acc_step;
                    breg <= b_step;
                    if (cnt == '0) begin
                        prod_r <= acc_step;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_vld;
    assign bus.prod      = prod_r;

endmodule

// File: tb/tb_gf_serial_mul.sv
// Directed and streaming checks for gf_serial_mul across field widths and digit sizes.
module tb_gf_serial_mul;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_aux = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Schoolbook carry-less product followed by polynomial long division
    function automatic logic [15:0] mdl(input int w, input logic [15:0] poly,
                                        input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        logic [31:0] full;
        p    = '0;
        full = {16'h0, poly} | (32'd1 << w);
        for (int i = 0; i < w; i++)
            if (b[i]) p = p ^ ({16'h0, a} << i);
        for (int i = 2 * w - 2; i >= w; i--)
            if (p[i]) p = p ^ (full << (i - w));
        return p[15:0];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out at cycle %0d", nm, cyc);
    endtask

    // ------------------------------------------------------------------
    // Main instance: W=8, AES polynomial, one bit per cycle
    // ------------------------------------------------------------------
    gf_serial_mul_if #(.W(8)) m_if();

    gf_serial_mul #(.W(8), .POLY(8'h1B), .DIGIT(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (m_if.slave)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [7:0] a, input logic [7:0] b, output int acc_cyc);
        bit ok;
        ok = 1'b0;
        acc_cyc = 0;
        m_if.a = a;
        m_if.b = b;
        m_if.in_valid = 1'b1;
        for (int t = 0; t < 50; t++) begin
            if (m_if.in_ready) begin
                acc_cyc = cyc;
                ok = 1'b1;
                tick();
                break;
            end
            tick();
        end
        m_if.in_valid = 1'b0;
        if (!ok) timeout("accept");
    endtask

    task automatic wait_out(output int seen_cyc);
        bit ok;
        ok = 1'b0;
        seen_cyc = 0;
        for (int t = 0; t < 50; t++) begin
            if (m_if.out_valid) begin
                seen_cyc = cyc;
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) timeout("out_valid");
    endtask

    initial begin
        int ac;
        int sc;
        bit all_done;

        vecs[0]  = '{8'h57, 8'h83, 8'hC1};
        vecs[1]  = '{8'h57, 8'h13, 8'hFE};
        vecs[2]  = '{8'h57, 8'h02, 8'hAE};
        vecs[3]  = '{8'h57, 8'h04, 8'h47};
        vecs[4]  = '{8'h57, 8'h08, 8'h8E};
        vecs[5]  = '{8'h57, 8'h10, 8'h07};
        vecs[6]  = '{8'h02, 8'h80, 8'h1B};
        vecs[7]  = '{8'h80, 8'h02, 8'h1B};
        vecs[8]  = '{8'h00, 8'hA5, 8'h00};
        vecs[9]  = '{8'hA5, 8'h00, 8'h00};
        vecs[10] = '{8'hA5, 8'h01, 8'hA5};
        vecs[11] = '{8'h01, 8'hC3, 8'hC3};

        m_if.in_valid  = 1'b0;
        m_if.out_ready = 1'b1;
        m_if.a = '0;
        m_if.b = '0;

        // Reset behaviour
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(m_if.in_ready), 32'd0);
        chk("rst_out_valid", 32'(m_if.out_valid), 32'd0);
        rst = 1'b0;
        rst_aux = 1'b0;
        tick();
        chk("post_rst_in_ready", 32'(m_if.in_ready), 32'd1);
        chk("post_rst_out_valid", 32'(m_if.out_valid), 32'd0);
        chk("post_rst_prod", 32'(m_if.prod), 32'd0);

        // Table of directed products with latency check
        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].a, vecs[i].b, ac);
            wait_out(sc);
            chk($sformatf("prod_%02h_x_%02h", vecs[i].a, vecs[i].b), 32'(m_if.prod), 32'(vecs[i].exp));
            chk($sformatf("lat_%0d", i), 32'(sc - ac), 32'd9);
            tick();
            chk($sformatf("idle_after_%0d", i), 32'(m_if.in_ready), 32'd1);
            chk($sformatf("ov_drop_%0d", i), 32'(m_if.out_valid), 32'd0);
        end

        // Back-pressure: hold result for 20 cycles while operands churn
        m_if.out_ready = 1'b0;
        issue(8'h57, 8'h83, ac);
        wait_out(sc);
        for (int i = 0; i < 20; i++) begin
            chk("bp_out_valid", 32'(m_if.out_valid), 32'd1);
            chk("bp_prod", 32'(m_if.prod), 32'hC1);
            chk("bp_in_ready", 32'(m_if.in_ready), 32'd0);
            m_if.in_valid = 1'($urandom_range(0, 1));
            m_if.a = 8'($urandom);
            m_if.b = 8'($urandom);
            tick();
        end
        m_if.in_valid = 1'b0;
        m_if.out_ready = 1'b1;
        chk("bp_release_prod", 32'(m_if.prod), 32'hC1);
        chk("bp_release_valid", 32'(m_if.out_valid), 32'd1);
        tick();
        chk("bp_after_in_ready", 32'(m_if.in_ready), 32'd1);
        chk("bp_after_out_valid", 32'(m_if.out_valid), 32'd0);

        // Reset in the third CALC cycle
        issue(8'h57, 8'h83, ac);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rcalc_out_valid", 32'(m_if.out_valid), 32'd0);
        chk("rcalc_prod", 32'(m_if.prod), 32'd0);
        chk("rcalc_in_ready", 32'(m_if.in_ready), 32'd0);
        tick();
        chk("rcalc_idle", 32'(m_if.in_ready), 32'd1);
        for (int i = 0; i < 12; i++) begin
            chk("rcalc_no_spurious", 32'(m_if.out_valid), 32'd0);
            tick();
        end

        // Reset in DONE with the consumer stalled
        m_if.out_ready = 1'b0;
        issue(8'h57, 8'h13, ac);
        wait_out(sc);
        chk("rdone_pre_prod", 32'(m_if.prod), 32'hFE);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rdone_out_valid", 32'(m_if.out_valid), 32'd0);
        chk("rdone_prod", 32'(m_if.prod), 32'd0);
        tick();
        chk("rdone_idle", 32'(m_if.in_ready), 32'd1);
        for (int i = 0; i < 12; i++) begin
            chk("rdone_no_spurious", 32'(m_if.out_valid), 32'd0);
            tick();
        end

        // Fresh operation after the resets
        m_if.out_ready = 1'b1;
        issue(8'h02, 8'h80, ac);
        wait_out(sc);
        chk("fresh_prod", 32'(m_if.prod), 32'h1B);
        chk("fresh_lat", 32'(sc - ac), 32'd9);
        tick();

        // Wait for the auxiliary instances
        all_done = 1'b0;
        for (int t = 0; t < 40000; t++) begin
            if (g_ex[0].done && g_ex[1].done && g_st[0].done && g_st[1].done &&
                g_st[2].done && g_st[3].done) begin
                all_done = 1'b1;
                break;
            end
            tick();
        end
        if (!all_done) timeout("aux_done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // ------------------------------------------------------------------
    // W=4, P=x^4+x+1: exhaustive operands for DIGIT=1 and DIGIT=2
    // ------------------------------------------------------------------
    for (genvar g = 0; g < 2; g++) begin : g_ex
        localparam int unsigned DG = g + 1;
        bit done = 1'b0;
        logic [3:0] res [16][16];

        gf_serial_mul_if #(.W(4)) x_if();

        gf_serial_mul #(.W(4), .POLY(4'h3), .DIGIT(DG)) u_dut (
            .clk (clk),
            .rst (rst_aux),
            .bus (x_if.slave)
        );

        initial begin
            bit ok;
            x_if.in_valid  = 1'b0;
            x_if.out_ready = 1'b1;
            x_if.a = '0;
            x_if.b = '0;
            wait (rst_aux == 1'b0);
            @(posedge clk);
            #1;
            for (int ai = 0; ai < 16; ai++) begin
                for (int bi = 0; bi < 16; bi++) begin
                    x_if.a = 4'(ai);
                    x_if.b = 4'(bi);
                    x_if.in_valid = 1'b1;
                    ok = 1'b0;
                    for (int t = 0; t < 40; t++) begin
                        if (x_if.in_ready) begin
                            ok = 1'b1;
                            @(posedge clk);
                            #1;
                            break;
                        end
                        @(posedge clk);
                        #1;
                    end
                    x_if.in_valid = 1'b0;
                    if (!ok) timeout("w4_accept");
                    ok = 1'b0;
                    for (int t = 0; t < 40; t++) begin
                        if (x_if.out_valid) begin
                            ok = 1'b1;
                            break;
                        end
                        @(posedge clk);
                        #1;
                    end
                    if (!ok) timeout("w4_out_valid");
                    res[ai][bi] = x_if.prod;
                    chk($sformatf("w4d%0d_%0h_x_%0h", DG, ai, bi), 32'(x_if.prod),
                        32'(mdl(4, 16'h3, 16'(ai), 16'(bi))));
                    @(posedge clk);
                    #1;
                end
            end
            chk($sformatf("w4d%0d_7_x_b", DG), 32'(res[7][11]), 32'h4);
            for (int ai = 0; ai < 16; ai++) begin
                chk($sformatf("w4d%0d_zero_%0h", DG, ai), 32'(res[ai][0]), 32'd0);
                chk($sformatf("w4d%0d_one_%0h", DG, ai), 32'(res[ai][1]), 32'(ai));
                for (int bi = ai + 1; bi < 16; bi++)
                    chk($sformatf("w4d%0d_swap_%0h_%0h", DG, ai, bi),
                        32'(res[ai][bi]), 32'(res[bi][ai]));
            end
            done = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // W=8 streaming with random gaps for DIGIT=1,2,4,8
    // ------------------------------------------------------------------
    for (genvar g = 0; g < 4; g++) begin : g_st
        localparam int unsigned DG = 1 << g;
        localparam int unsigned NS = 8 / DG;
        bit done = 1'b0;
        bit mon_stop = 1'b0;
        int n_rx = 0;
        logic [7:0] exp_q [$];

        gf_serial_mul_if #(.W(8)) s_if();

        gf_serial_mul #(.W(8), .POLY(8'h1B), .DIGIT(DG)) u_dut (
            .clk (clk),
            .rst (rst_aux),
            .bus (s_if.slave)
        );

        // Producer
        initial begin
            bit ok;
            s_if.in_valid = 1'b0;
            s_if.a = '0;
            s_if.b = '0;
            wait (rst_aux == 1'b0);
            @(posedge clk);
            #1;
            for (int i = 0; i < 100; i++) begin
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk);
                    #1;
                end
                s_if.a = 8'($urandom);
                s_if.b = 8'($urandom);
                s_if.in_valid = 1'b1;
                ok = 1'b0;
                for (int t = 0; t < 200; t++) begin
                    if (s_if.in_ready) begin
                        ok = 1'b1;
                        @(posedge clk);
                        #1;
                        break;
                    end
                    @(posedge clk);
                    #1;
                end
                s_if.in_valid = 1'b0;
                if (!ok) begin
                    timeout($sformatf("st%0d_accept", DG));
                    break;
                end
            end
            for (int t = 0; t < 400; t++) begin
                if (n_rx >= 100) break;
                @(posedge clk);
                #1;
            end
            repeat (4) @(posedge clk);
            #1;
            mon_stop = 1'b1;
            chk($sformatf("st%0d_count", DG), 32'(n_rx), 32'd100);
            chk($sformatf("st%0d_leftover", DG), 32'(exp_q.size()), 32'd0);
            done = 1'b1;
        end

        // Consumer with random stalls
        initial begin
            s_if.out_ready = 1'b0;
            wait (rst_aux == 1'b0);
            for (int t = 0; t < 20000; t++) begin
                if (done) break;
                @(posedge clk);
                #1;
                s_if.out_ready = 1'($urandom_range(0, 1));
            end
        end

        // Scoreboard sampled mid-cycle
        initial begin
            int acc_cyc;
            bit lat_pend;
            lat_pend = 1'b0;
            acc_cyc = 0;
            wait (rst_aux == 1'b0);
            for (int t = 0; t < 20000; t++) begin
                @(negedge clk);
                if (mon_stop) break;
                if (s_if.in_valid && s_if.in_ready) begin
                    exp_q.push_back(mdl(8, 16'h1B, 16'(s_if.a), 16'(s_if.b))[7:0]);
                    acc_cyc = cyc;
                    lat_pend = 1'b1;
                end
                if (s_if.out_valid && lat_pend) begin
                    chk($sformatf("st%0d_latency", DG), 32'(cyc - acc_cyc), 32'(NS + 1));
                    lat_pend = 1'b0;
                end
                if (s_if.out_valid && s_if.out_ready) begin
                    if (exp_q.size() == 0) begin
                        timeout($sformatf("st%0d_duplicate", DG));
                    end else begin
                        chk($sformatf("st%0d_prod_%0d", DG, n_rx), 32'(s_if.prod),
                            32'(exp_q.pop_front()));
                    end
                    n_rx++;
                end
            end
        end
    end

endmodule

// File: doc/gf_serial_mul.md
# gf_serial_mul

Parametrised, sequential GF(2^W) multiplier for the AES datapath and its test infrastructure. It generalises the combinational 4-bit field multiplier to any field width W and any reduction polynomial. It computes the product over W/DIGIT clock cycles using MSB-first Horner iteration. Operands enter and results leave through valid/ready handshakes, so the block can sit between the key-schedule/MixColumns control and any buffering stage without extra glue.

## Interface
Parameters:
- W, 8, field width in bits; legal range 2..16.
- POLY, 8'h1B, low W bits of the reduction polynomial; the x^W term is implicit, so the AES field is x^8+x^4+x^3+x+1.
- DIGIT, 1, operand-B bits consumed per cycle; must divide W, otherwise elaboration fails.

Ports (one clock; reset is synchronous and active-high):
- clk, in, 1, sole clock; all state updates on the rising edge.
- rst, in, 1, synchronous, active-high reset.
- in_valid, in, 1, operands a/b are valid.
- in_ready, out, 1, block can accept operands.
- a, in, W, multiplicand.
- b, in, W, multiplier.
- out_valid, out, 1, prod is valid.
- out_ready, in, 1, consumer accepts prod.
- prod, out, W, a·b mod P(x).

## Operation
- States:
  - IDLE: in_ready=1.
  - CALC: runs N=W/DIGIT cycles.
  - DONE: out_valid=1.
- Registers:
  - areg (W).
  - breg (W, shift register).
  - acc (W).
  - cnt (ceil(log2 N)+1 bits).
- IDLE, when in_valid && in_ready: load areg=a, breg=b, acc=0, cnt=N-1, go to CALC. Otherwise stay in IDLE.
- CALC, each cycle: apply DIGIT unrolled Horner steps, taking breg bits MSB first. Per step:
  - acc = xtime(acc) ^ (bit ? areg : 0).
  - xtime(v) = (v<<1)[W-1:0] ^ (v[W-1] ? POLY : 0).
  - Then breg <<= DIGIT.
- CALC, when cnt==0: latch prod=acc after the final step, go to DONE. Otherwise decrement cnt.
- DONE: hold prod and out_valid stable until out_ready. On out_valid && out_ready, go to IDLE.
- Input handshake: in_valid and operands are ignored outside IDLE. No overlap: there is one operation in flight at a time.
- Arithmetic is pure XOR/shift with no carries. The result is always fully reduced (< 2^W).
- Operand edge cases:
  - a==0 or b==0 gives prod=0.
  - b==1 gives prod=a.
  - b has its MSB set: reduction applies from the second step onward.
- Reset (rst=1 at a rising edge) applies in any state, including mid-CALC and DONE with out_ready low:
  - Next state is IDLE; acc, areg, breg, cnt and prod are cleared to 0.
  - The in-flight result is discarded, with no out_valid pulse.
- Output values under reset:
  - in_ready=0 and out_valid=0 while rst is high.
  - After reset: in_ready=1, out_valid=0, prod=0.

## Timing
- The accept cycle is c, the cycle where in_valid && in_ready is sampled.
- Cycles c+1 .. c+N are CALC.
- out_valid is first high in cycle c+N+1:
  - W=8, DIGIT=1 gives 9 cycles from accept to result.
  - W=8, DIGIT=4 gives 3 cycles.
- If out_ready is high in cycle c+N+1, the block is in IDLE in c+N+2, with in_ready=1.
- Minimum initiation interval is N+2 cycles.
- in_ready and out_valid are decoded from the state register only, with no combinational path from in_valid or out_ready.
- prod is registered and changes only on the CALC→DONE edge and on reset.

## Test plan
- W=8, POLY=8'h1B, DIGIT=1. Expected products:
  - a=8'h57, b=8'h83 gives prod=8'hC1.
  - a=8'h57, b=8'h13 gives prod=8'hFE.
  - Both results have out_valid exactly 9 cycles after accept.
- W=4, POLY=4'h3, DIGIT=1 and DIGIT=2, exhaustive 16×16 operands, each pair also run swapped (a,b and b,a):
  - a=7, b=B gives 4.
  - Results match a bitwise software model.
  - Swapped pairs give equal results.
  - 0 and 1 behave as annihilator and identity.
- Back-pressure: hold out_ready=0 for 20 cycles in DONE while toggling in_valid and the operands.
  - prod and out_valid stay stable and in_ready stays 0.
  - With W=8 defaults and a=8'h57, b=8'h83, the first out_ready=1 cycle completes the handshake with prod=8'hC1, and in_ready=1 the following cycle.
- Reset mid-CALC (3rd cycle of CALC), then reset in DONE with out_ready low:
  - The next cycle is IDLE with prod=0 and out_valid=0.
  - No spurious result appears.
  - A fresh operation afterwards (a=8'h02, b=8'h80) gives 8'h1B.
- Streaming 100 random W=8 operations with random in_valid/out_ready gaps, DIGIT=1,2,4,8:
  - Every result matches the model, none is dropped or duplicated, and latency is N+1 cycles from accept to out_valid.
